// File: rtl/corescore_stream_arbiter_pkg.sv
// Shared constants and FSM encoding for the corescore stream arbiter and its
// output register slice.
package corescore_stream_arbiter_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/corescore_stream_reg.sv
// Single-entry AXI-Stream register slice: data/last/valid are registered, and
// ready passes straight through when the slot is empty or draining.
module corescore_stream_reg
    import corescore_stream_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             o_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             i_tready
);

    assign o_tready = ~o_tvalid | i_tready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
        end else if (i_tvalid && o_tready) begin
            // a load while draining keeps the slot full, giving one beat per cycle
            o_tvalid <= 1'b1;
            o_tdata  <= i_tdata;
            o_tlast  <= i_tlast;
        end else if (i_tready) begin
            o_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/corescore_stream_arbiter.sv
// Packet-aware round-robin arbiter merging NUM_SOURCES byte streams onto one
// emitter stream, with a mid-packet stall watchdog.
module corescore_stream_arbiter
    import corescore_stream_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SOURCES = 4,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [DATA_W*NUM_SOURCES-1:0] i_tdata,
    input  logic [NUM_SOURCES-1:0]        i_tlast,
    input  logic [NUM_SOURCES-1:0]        i_tvalid,
    output logic [NUM_SOURCES-1:0]        o_tready,
    output logic [DATA_W-1:0]             o_tdata,
    output logic                          o_tlast,
    output logic                          o_tvalid,
    input  logic                          i_tready,
    output logic [NUM_SOURCES-1:0]        o_grant,
    output logic                          o_timeout
);

    localparam int unsigned IDX_W = $clog2(NUM_SOURCES);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [NUM_SOURCES-1:0] ONE = NUM_SOURCES'(1);

    state_t               state;
    logic [IDX_W-1:0]     g;
    logic [IDX_W-1:0]     ptr;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_SOURCES-1:0] grant_q;
    logic                 timeout_q;

    logic [DATA_W-1:0]    src_data;
    logic                 src_last;
    logic                 src_valid;
    logic                 slot_ready;
    logic                 accept;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W-1:0]     g_next;

    // Lowest offset from base wins, so iterate offsets from highest down.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SOURCES-1:0] req,
                                                 input logic [IDX_W-1:0]       base);
        int unsigned idx;
        logic [IDX_W-1:0] sel;
        sel = base;
        for (int unsigned i = NUM_SOURCES; i > 0; i--) begin
            idx = (int'(base) + i - 1) % NUM_SOURCES;
            if (req[idx]) sel = IDX_W'(idx);
        end
        return sel;
    endfunction

    always_comb begin
        src_data  = '0;
        src_last  = 1'b0;
        src_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
            if (g == IDX_W'(k)) begin
                src_data  = i_tdata[DATA_W*k +: DATA_W];
                src_last  = i_tlast[k];
                src_valid = i_tvalid[k];
            end
        end
    end

    assign pick   = rr_pick(i_tvalid, ptr);
    assign g_next = (g == IDX_W'(NUM_SOURCES - 1)) ? '0 : g + 1'b1;
    assign accept = (state == ST_BUSY) && src_valid && slot_ready;

    always_comb begin
        o_tready = '0;
        if (state == ST_BUSY) o_tready = (ONE << g) & {NUM_SOURCES{slot_ready}};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            g         <= '0;
            ptr       <= '0;
            cnt       <= '0;
            grant_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (|i_tvalid) begin
                        g       <= pick;
                        grant_q <= ONE << pick;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept && src_last) begin
                        state   <= ST_IDLE;
                        grant_q <= '0;
                        ptr     <= g_next;
                        cnt     <= '0;
                    end else if (src_valid) begin
                        cnt <= '0;
                    end else if (TIMEOUT > 0 && cnt == CNT_LAST) begin
                        // this is the TIMEOUT-th consecutive stall cycle
                        state     <= ST_IDLE;
                        grant_q   <= '0;
                        ptr       <= g_next;
                        cnt       <= '0;
                        timeout_q <= 1'b1;
                    end else if (TIMEOUT > 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_grant   = grant_q;
    assign o_timeout = timeout_q;

    corescore_stream_reg #(
        .WIDTH (DATA_W)
    ) u_out_reg (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_tdata  (src_data),
        .i_tlast  (src_last),
        .i_tvalid (accept),
        .o_tready (slot_ready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .i_tready (i_tready)
    );

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Scoreboard bench for corescore_stream_arbiter: a packet-level reference model
// predicts grants, ready and emitted beats while a monitor checks the output.
module tb_corescore_stream_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [8*N-1:0] tdata = '0;
    logic [N-1:0]   tlast = '0;
    logic [N-1:0]   tvalid = '0;
    logic [N-1:0]   tready_o;
    logic [7:0]     odata;
    logic           olast;
    logic           ovalid;
    logic           itready = 1'b1;
    logic [N-1:0]   grant;
    logic           otimeout;

    corescore_stream_arbiter #(
        .NUM_SOURCES (N),
        .TIMEOUT     (TMO)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_tdata   (tdata),
        .i_tlast   (tlast),
        .i_tvalid  (tvalid),
        .o_tready  (tready_o),
        .o_tdata   (odata),
        .o_tlast   (olast),
        .o_tvalid  (ovalid),
        .i_tready  (itready),
        .o_grant   (grant),
        .o_timeout (otimeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // stimulus state: per-source beat queues {last, data}
    logic [8:0] src_q [N][$];
    bit         hold [N];
    int         pct = 100;
    int         tready_mode = 0;
    int         cyc = 0;

    // reference model state
    bit         m_busy = 0;
    int         m_g = 0;
    int         m_ptr = 0;
    int         m_cnt = 0;
    bit         m_ovalid = 0;
    bit         m_to = 0;
    int         m_acc = -1;
    logic [8:0] sb_q [$];

    // monitor bookkeeping
    int         to_seen = 0;
    bit         log_en = 0;
    int         grant_log [$];
    logic [N-1:0] prev_grant = '0;
    bit         p_stall = 0;
    logic [8:0] p_beat = '0;

    always @(negedge clk) begin : model
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_tr;
        bit acc;
        exp_grant = '0;
        exp_tr    = '0;
        if (m_busy) exp_grant[m_g] = 1'b1;
        check("grant", grant, exp_grant);
        check("timeout", otimeout, m_to);
        check("tvalid", ovalid, m_ovalid);
        if (m_busy && (!m_ovalid || itready)) exp_tr[m_g] = 1'b1;
        check("tready", tready_o, exp_tr);

        m_acc = -1;
        if (!rst_n) begin
            m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_ovalid = 0; m_to = 0;
            sb_q.delete();
        end else begin
            acc = m_busy && tvalid[m_g] && (!m_ovalid || itready);
            m_to = 0;
            m_ovalid = acc || (m_ovalid && !itready);
            if (acc) begin
                sb_q.push_back({tlast[m_g], tdata[8*m_g +: 8]});
                m_acc = m_g;
            end
            if (!m_busy) begin
                m_cnt = 0;
                for (int i = 0; i < N; i++) begin
                    if (!m_busy && tvalid[(m_ptr + i) % N]) begin
                        m_busy = 1;
                        m_g = (m_ptr + i) % N;
                    end
                end
            end else if (acc && tlast[m_g]) begin
                m_busy = 0; m_ptr = (m_g + 1) % N; m_cnt = 0;
            end else if (tvalid[m_g]) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == TMO) begin
                    m_busy = 0; m_ptr = (m_g + 1) % N; m_cnt = 0; m_to = 1;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        if (rst_n && p_stall) check("hold_stable", {olast, odata}, p_beat);
        if (rst_n && ovalid && itready) begin
            if (sb_q.size() == 0) check("sb_underflow", sb_q.size(), 1);
            else check("beat", {olast, odata}, sb_q.pop_front());
        end
        p_stall = rst_n && ovalid && !itready;
        p_beat  = {olast, odata};
        if (otimeout === 1'b1) to_seen++;
        if (log_en && grant !== prev_grant && grant !== '0) begin
            for (int k = 0; k < N; k++) if (grant[k]) grant_log.push_back(k);
        end
        prev_grant = grant;
    end

    task automatic drive_inputs();
        if (m_acc >= 0) begin
            void'(src_q[m_acc].pop_front());
            hold[m_acc] = 0;
        end
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() == 0) begin
                hold[k]  = 0;
                tvalid[k] = 1'b0;
            end else begin
                if (!hold[k]) hold[k] = ($urandom_range(99) < pct);
                tvalid[k]        = hold[k];
                tdata[8*k +: 8]  = src_q[k][0][7:0];
                tlast[k]         = src_q[k][0][8];
            end
        end
        case (tready_mode)
            0:       itready = 1'b1;
            1:       itready = ($urandom_range(99) < 70);
            default: itready = (cyc % 4 == 0) || (cyc % 4 == 3);
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int limit);
        int left;
        for (int c = 0; c < limit; c++) begin
            left = sb_q.size() + int'(ovalid) + int'(m_busy);
            for (int k = 0; k < N; k++) left += src_q[k].size();
            if (left == 0) break;
            step();
        end
        left = sb_q.size() + int'(ovalid) + int'(m_busy);
        for (int k = 0; k < N; k++) left += src_q[k].size();
        check("drain_bound", left, 0);
    endtask

    initial begin
        int len;
        int waited;
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};

        // reset while every source is already requesting
        for (int k = 0; k < N; k++) src_q[k].push_back(9'h100 | 9'(8'hC0 + k));
        do_reset(3);
        drain(200);

        // two 3-byte packets from sources 1 and 3
        do_reset(2);
        src_q[1] = '{9'h041, 9'h042, 9'h143};
        src_q[3] = '{9'h061, 9'h062, 9'h163};
        drain(200);

        // fairness with continuous single-byte packets
        do_reset(2);
        grant_log.delete();
        log_en = 1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) src_q[k].push_back(9'h100 | 9'(8'h80 + 16*k + r));
        drain(200);
        log_en = 0;
        check("grant_log_len", grant_log.size(), 8);
        for (int i = 0; i < 6; i++)
            if (i < grant_log.size()) check("grant_order", grant_log[i], exp_order[i]);

        // back-pressure pattern 1,0,0,1 across a 4-byte packet
        tready_mode = 2;
        src_q[0] = '{9'h010, 9'h011, 9'h012, 9'h113};
        drain(200);
        tready_mode = 0;

        // watchdog: source 2 stalls mid-packet, source 3 waiting
        do_reset(2);
        to_seen = 0;
        src_q[2] = '{9'h0A0, 9'h0A1};
        src_q[3] = '{9'h1B0};
        drain(200);
        check("timeout_pulses", to_seen, 1);

        // reset mid-packet with a beat held in the output register
        do_reset(2);
        tready_mode = 2;
        src_q[0] = '{9'h050, 9'h051, 9'h052, 9'h053, 9'h154};
        waited = 0;
        while (!ovalid && waited < 20) begin
            step();
            waited++;
        end
        check("ovalid_before_reset", ovalid, 1'b1);
        do_reset(1);
        drain(300);
        tready_mode = 0;

        // randomized traffic
        tready_mode = 1;
        pct = 60;
        for (int round = 0; round < 4; round++) begin
            for (int k = 0; k < N; k++) begin
                for (int p = 0; p < int'($urandom_range(3)); p++) begin
                    len = $urandom_range(5, 1);
                    for (int b = 0; b < len; b++)
                        src_q[k].push_back({(b == len - 1), 8'($urandom)});
                end
            end
            drain(5000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/corescore_stream_arbiter.md
Name: corescore_stream_arbiter

Overview:
Packet-aware round-robin arbiter that shares one 8-bit AXI-Stream sink (the UART emitter) between NUM_SOURCES byte-stream producers (SERV core report streams).
- Grant is held for a whole packet, from the first beat up to and including the tlast beat.
- A registered output stage isolates emitter timing.
- A watchdog releases a source that stalls mid-packet.
- Sits between the core array and the emitter in corescorecore-level designs.

Parameters:
NUM_SOURCES, 4, number of requesting streams (2..64)
TIMEOUT, 1024, cycles a granted source may hold tvalid low mid-packet before forced release; 0 disables the watchdog

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_tdata  in  8*NUM_SOURCES  source k data at bits [8k+7:8k]
i_tlast  in  NUM_SOURCES  per-source end of packet
i_tvalid  in  NUM_SOURCES  per-source beat valid
o_tready  out  NUM_SOURCES  per-source ready
o_tdata  out  8  merged stream data to emitter
o_tlast  out  1  merged stream end of packet
o_tvalid  out  1  merged stream valid
i_tready  in  1  emitter ready
o_grant  out  NUM_SOURCES  one-hot current grant, all zero when idle
o_timeout  out  1  one-cycle pulse on watchdog release

Behaviour:
- Single clock, synchronous active-low reset. All state updates occur on the rising edge of i_clk. Reset is sampled at that edge.
- Reset values:
  - o_tvalid=0, o_tdata=0, o_tlast=0
  - o_grant=0, o_timeout=0
  - state=IDLE, rr pointer=0, watchdog count=0
- Reset mid-packet: any buffered beat is discarded and the packet is truncated. There is no recovery.
- States:
  - IDLE: no grant.
  - BUSY: locked to index g.
- IDLE behaviour:
  - Select the first k with i_tvalid[k]=1, searching from ptr upward and wrapping modulo NUM_SOURCES.
  - Register g=k, o_grant=onehot(k) and move to BUSY. This costs one cycle; no beat transfers in IDLE.
  - With no i_tvalid asserted, remain in IDLE.
- BUSY behaviour:
  - o_tready[k] = (k==g) & (~o_tvalid | i_tready). This term is combinational from i_tready.
  - o_tready is 0 for all sources in IDLE and for non-granted sources.
  - An input beat is accepted when i_tvalid[g] & o_tready[g]. The beat's data and last are loaded into the output register and o_tvalid is set the next cycle.
  - Output register is a single entry:
    - Cleared when i_tready & o_tvalid and no new beat is loaded the same cycle.
    - A simultaneous drain and load keeps o_tvalid=1 with the new data, giving full throughput.
- Packet end: accepting a beat with i_tlast[g]=1 moves the block to IDLE next cycle, clears o_grant and sets ptr=(g+1) mod NUM_SOURCES.
- Back-to-back packets from different sources are separated by one idle arbitration cycle.
- Watchdog (TIMEOUT>0):
  - In BUSY, count increments each cycle i_tvalid[g]=0 and resets to 0 on any cycle i_tvalid[g]=1.
  - When count reaches TIMEOUT, the block:
    - moves to IDLE;
    - clears o_grant;
    - sets ptr=(g+1) mod NUM_SOURCES;
    - pulses o_timeout for one cycle;
    - resets count.
  - Already-registered output beats still drain normally. No tlast is synthesised.
  - Count is held at 0 in IDLE.
- Latency: first beat reaches o_tvalid 2 cycles after i_tvalid rises in IDLE (arbitration plus register). Each later beat appears 1 cycle after its acceptance.
- The arbiter never accepts from two sources in one cycle, and never changes g while BUSY except via tlast or timeout.
- Fairness: with all sources continuously requesting, grants rotate 0,1,2,...,N-1,0.
- Downstream back-pressure (i_tready=0) with o_tvalid=1 holds o_tdata and o_tlast stable.

Decomposition:
- Shared package or header: DATA_W=8 constant and the state encoding (ST_IDLE, ST_BUSY). Count width is derived as $clog2(TIMEOUT+1).
- One sub-module, corescore_stream_reg: the single-entry output register slice with valid/ready, data and last. It is reusable at other stream boundaries.
- Round-robin search is a function or loop inside the arbiter.

Test Plan:
- Reset with i_rst_n=0 for 3 cycles while sources drive valid -> all outputs 0, o_tready all 0. First grant to source 0 occurs one cycle after release.
- Sources 1 and 3 each present a 3-byte packet (0x41,0x42,0x43 with tlast; 0x61,0x62,0x63 with tlast), i_tready=1 -> output is 41,42,43 then 61,62,63 with tlast only on 43 and 63. The packets never interleave and there is one idle cycle between them.
- All 4 sources continuously request 1-byte packets -> grant order 0,1,2,3,0,1 and ptr wraps from 3 to 0.
- i_tready toggles 1,0,0,1 during a 4-byte packet -> o_tdata/o_tlast stay stable while stalled. No byte is lost or duplicated, and o_tready[g] drops whenever o_tvalid=1 and i_tready=0.
- TIMEOUT=8: source 2 sends 2 bytes without tlast then drops valid -> o_timeout pulses on the 8th stall cycle and grant moves to the next requester (source 3). The 2 bytes appear on the output.
- Assert i_rst_n=0 mid-packet with o_tvalid=1 -> next cycle o_tvalid=0 and o_grant=0, and arbitration restarts from ptr=0.
